// File: rtl/priority_arbiter_fsm_if.sv
// Request/grant bundle between four requesters and the shared-resource select mux.
// master drives requests; slave (the arbiter) returns grant, index, valid and preempt.
interface priority_arbiter_fsm_if;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] out;
   logic       v;
   logic       preempt;

   modport master (output req, input gnt, input out, input v, input preempt);
   modport slave  (input req, output gnt, output out, output v, output preempt);
endinterface

// File: rtl/priority_arbiter_fsm.sv
// 4-way fixed/round-robin arbiter: one-hot grant + index, 1 cycle from req, all outputs registered.
// No backpressure: the grant holds until the winner drops req or MAX_HOLD expires, then one idle gap.
module priority_arbiter_fsm #(
   parameter bit          RR_EN    = 1'b1,
   parameter int unsigned MAX_HOLD = 8
) (
   input logic                   clk,
   input logic                   rst,
   priority_arbiter_fsm_if.slave arb
);
   localparam int HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t          r_state, w_state_nx;
   logic [3:0]      r_gnt,   w_gnt_nx;
   logic [1:0]      r_out,   w_out_nx;
   logic            r_v,     w_v_nx;
   logic            r_pre,   w_pre_nx;
   logic [1:0]      r_ptr,   w_ptr_nx;
   logic [HW-1:0]   r_cnt,   w_cnt_nx;

   logic [1:0]      w_base;
   logic [1:0]      w_idx;
   logic [1:0]      w_win;
   logic            w_found;
   logic            w_limit;

   // Downward scan from the priority pointer; fixed mode always starts at index 3.
   always_comb begin
      w_base  = RR_EN ? r_ptr : 2'd3;
      w_win   = w_base;
      w_idx   = w_base;
      w_found = 1'b0;
      for (int s = 0; s < 4; s++) begin
         w_idx = w_base - 2'(s);
         if (!w_found && arb.req[w_idx]) begin
            w_win   = w_idx;
            w_found = 1'b1;
         end
      end
   end

   assign w_limit = (MAX_HOLD != 0) && (r_cnt == HW'(MAX_HOLD));

   always_comb begin
      w_state_nx = r_state;
      w_gnt_nx   = r_gnt;
      w_out_nx   = r_out;
      w_v_nx     = r_v;
      w_pre_nx   = 1'b0;
      w_ptr_nx   = r_ptr;
      w_cnt_nx   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_state_nx = S_GRANT;
               w_gnt_nx   = 4'b0001 << w_win;
               w_out_nx   = w_win;
               w_v_nx     = 1'b1;
               w_cnt_nx   = HW'(1);
               if (RR_EN) w_ptr_nx = w_win - 2'd1;
            end
         end
         S_GRANT: begin
            // A dropped request takes precedence over the hold limit: no preempt pulse.
            if (!arb.req[r_out]) begin
               w_state_nx = S_IDLE;
               w_gnt_nx   = 4'b0000;
               w_v_nx     = 1'b0;
            end else if (w_limit) begin
               w_state_nx = S_IDLE;
               w_gnt_nx   = 4'b0000;
               w_v_nx     = 1'b0;
               w_pre_nx   = 1'b1;
            end else if (r_cnt != {HW{1'b1}}) begin
               w_cnt_nx = r_cnt + HW'(1);
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_gnt   <= 4'b0000;
         r_out   <= 2'b00;
         r_v     <= 1'b0;
         r_pre   <= 1'b0;
         r_ptr   <= 2'd3;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_gnt   <= w_gnt_nx;
         r_out   <= w_out_nx;
         r_v     <= w_v_nx;
         r_pre   <= w_pre_nx;
         r_ptr   <= w_ptr_nx;
         r_cnt   <= w_cnt_nx;
      end
   end

   assign arb.gnt     = r_gnt;
   assign arb.out     = r_out;
   assign arb.v       = r_v;
   assign arb.preempt = r_pre;
endmodule

// File: tb/tb_priority_arbiter_fsm.sv
// Three arbiter configurations share one req/rst stream and are compared every cycle against a reference model.
module tb_priority_arbiter_fsm;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;
   int         tests = 0;
   int         fails = 0;

   always #5 clk = ~clk;

   priority_arbiter_fsm_if if0();
   priority_arbiter_fsm_if if1();
   priority_arbiter_fsm_if if2();
   assign if0.req = req;
   assign if1.req = req;
   assign if2.req = req;

   priority_arbiter_fsm #(.RR_EN(1'b0), .MAX_HOLD(8)) dut0 (.clk(clk), .rst(rst), .arb(if0));
   priority_arbiter_fsm #(.RR_EN(1'b1), .MAX_HOLD(2)) dut1 (.clk(clk), .rst(rst), .arb(if1));
   priority_arbiter_fsm #(.RR_EN(1'b1), .MAX_HOLD(0)) dut2 (.clk(clk), .rst(rst), .arb(if2));

   logic [3:0] d_gnt [3];
   logic [1:0] d_out [3];
   logic       d_v   [3];
   logic       d_pre [3];
   assign d_gnt[0] = if0.gnt; assign d_out[0] = if0.out; assign d_v[0] = if0.v; assign d_pre[0] = if0.preempt;
   assign d_gnt[1] = if1.gnt; assign d_out[1] = if1.out; assign d_v[1] = if1.v; assign d_pre[1] = if1.preempt;
   assign d_gnt[2] = if2.gnt; assign d_out[2] = if2.out; assign d_v[2] = if2.v; assign d_pre[2] = if2.preempt;

   // Reference: who owns the resource (-1 = nobody), how long, and where the next scan starts.
   int P_RR [3] = '{0, 1, 1};
   int P_MH [3] = '{8, 2, 0};
   int m_own [3];
   int m_len [3];
   int m_ptr [3];
   int m_out [3];
   int m_pre [3];

   function automatic int pick(input logic [3:0] r, input int start);
      for (int s = 0; s < 4; s++) begin
         int idx;
         idx = (start - s + 4) % 4;
         if (r[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic model_edge();
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            m_own[k] = -1; m_len[k] = 0; m_ptr[k] = 3; m_out[k] = 0; m_pre[k] = 0;
         end else if (m_own[k] < 0) begin
            int w;
            m_pre[k] = 0;
            w = pick(req, (P_RR[k] != 0) ? m_ptr[k] : 3);
            if (w >= 0) begin
               m_own[k] = w; m_out[k] = w; m_len[k] = 1;
               if (P_RR[k] != 0) m_ptr[k] = (w + 3) % 4;
            end
         end else if (!req[m_own[k]]) begin
            m_own[k] = -1; m_pre[k] = 0;
         end else if (P_MH[k] != 0 && m_len[k] >= P_MH[k]) begin
            m_own[k] = -1; m_pre[k] = 1;
         end else begin
            m_len[k]++; m_pre[k] = 0;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 3; k++) begin
         logic [3:0] eg;
         eg = (m_own[k] < 0) ? 4'b0000 : (4'b0001 << m_own[k]);
         chk($sformatf("d%0d_gnt", k), 8'(d_gnt[k]), 8'(eg));
         chk($sformatf("d%0d_v", k),   8'(d_v[k]),   8'(m_own[k] >= 0));
         chk($sformatf("d%0d_out", k), 8'(d_out[k]), 8'(m_out[k]));
         chk($sformatf("d%0d_pre", k), 8'(d_pre[k]), 8'(m_pre[k]));
      end
   endtask

   task automatic step(input logic r, input logic [3:0] q);
      rst = r;
      req = q;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   int rot [$];
   int rot_exp [5] = '{3, 2, 1, 0, 3};

   initial begin
      for (int k = 0; k < 3; k++) begin
         m_own[k] = -1; m_len[k] = 0; m_ptr[k] = 3; m_out[k] = 0; m_pre[k] = 0;
      end
      #2;
      // Reset with every request asserted.
      step(1'b1, 4'b1111);
      step(1'b1, 4'b1111);
      chk("rst_gnt", 8'(if0.gnt), 8'h0);
      chk("rst_v",   8'(if1.v),   8'h0);
      // Round-robin rotation under a held 1111 (d1: MAX_HOLD=2).
      for (int i = 0; i < 16; i++) begin
         logic pv;
         pv = if1.v;
         step(1'b0, 4'b1111);
         if (i == 0) begin
            chk("first_gnt", 8'(if0.gnt), 8'h8);
            chk("first_out", 8'(if0.out), 8'h3);
         end
         if (if1.v && !pv) rot.push_back(int'(if1.out));
      end
      for (int i = 0; i < 5; i++)
         chk($sformatf("rr_rot%0d", i), 8'((i < rot.size()) ? rot[i] : -1), 8'(rot_exp[i]));
      // Reset in the middle of a grant.
      step(1'b1, 4'b1111);
      chk("midrst_v",   8'(if0.v),       8'h0);
      chk("midrst_pre", 8'(if1.preempt), 8'h0);
      // Fixed priority, drop, gap, regrant; ptr=3 again after reset.
      step(1'b0, 4'b0110);
      chk("fp_gnt", 8'(if0.gnt), 8'h4);
      chk("rr_ptr3", 8'(if1.out), 8'h2);
      step(1'b0, 4'b0010);
      chk("fp_gap", 8'(if0.gnt), 8'h0);
      step(1'b0, 4'b0010);
      chk("fp_gnt1", 8'(if0.gnt), 8'h2);
      // Other requests are ignored during a grant.
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 4'b1010);
         chk("ign_gnt", 8'(if0.gnt), 8'h2);
      end
      step(1'b0, 4'b1000);
      chk("ign_gap", 8'(if0.gnt), 8'h0);
      step(1'b0, 4'b1000);
      chk("ign_gnt3", 8'(if0.gnt), 8'h8);
      // Hold limit (d0: 8) versus unlimited hold (d2).
      step(1'b1, 4'b0000);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 4'b0001);
         chk("hold_gnt", 8'(if0.gnt), 8'h1);
      end
      step(1'b0, 4'b0001);
      chk("hold_pre",  8'(if0.preempt), 8'h1);
      chk("hold_gap",  8'(if0.gnt),     8'h0);
      step(1'b0, 4'b0001);
      chk("hold_regnt", 8'(if0.gnt),     8'h1);
      chk("hold_pre0",  8'(if0.preempt), 8'h0);
      for (int i = 0; i < 20; i++) step(1'b0, 4'b0001);
      chk("nolimit_gnt", 8'(if2.gnt), 8'h1);
      // Random traffic with occasional resets.
      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 39) == 0), 4'($urandom_range(0, 15)));
      // Long random holds so hold limits and saturation get exercised.
      for (int i = 0; i < 40; i++) begin
         logic [3:0] q;
         q = 4'($urandom_range(1, 15));
         for (int j = 0; j < $urandom_range(1, 12); j++) step(1'b0, q);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
